// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ requesters,
// dropping a frame (with an error pulse) if the transmitter never starts it.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [DATA_W-1:0]          o_tx_data,
  output logic                       o_tx_valid,
  input  logic                       i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_active,
  output logic                       o_err
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } state_t;

  state_t            state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     winner;
  logic [7:0]        cnt;
  logic              grant;
  logic [DATA_W-1:0] payload [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign payload[k] = i_req_data[k*DATA_W +: DATA_W];
  end

  // Walk from farthest to nearest so the requester right after last_grant wins.
  always_comb begin
    winner = last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (i_req_valid[GW'((int'(last_grant) + i) % NUM_REQ)]) begin
        winner = GW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign grant = i_rst_n && (state == IDLE) && !i_tx_busy && (|i_req_valid);

  always_comb begin
    o_req_ready = '0;
    if (grant) begin
      o_req_ready[winner] = 1'b1;
    end
  end

  assign o_tx_valid = (state == LOAD);
  assign o_active   = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      o_grant_id <= '0;
      o_tx_data  <= '0;
      cnt        <= '0;
      o_err      <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            o_tx_data  <= payload[winner];
            last_grant <= winner;
            o_grant_id <= winner;
            state      <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (i_tx_busy) begin
            state <= WAIT_END;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            // Transmitter never picked the frame up: drop it, keep last_grant.
            o_err <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_END: begin
          if (!i_tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic, checked cycle by cycle
// against an event-timestamp reference model and a frame scoreboard.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_req_valid;
  logic [N*W-1:0]  i_req_data;
  logic [N-1:0]    o_req_ready;
  logic [W-1:0]    o_tx_data;
  logic            o_tx_valid;
  logic            i_tx_busy;
  logic [GW-1:0]   o_grant_id;
  logic            o_active;
  logic            o_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_busy   (i_tx_busy),
    .o_grant_id  (o_grant_id),
    .o_active    (o_active),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Requester queues and handshake flags shared between driver and monitor.
  logic [W-1:0] rq [N][$];
  logic [N-1:0] acc = '0;
  bit           txv_flag = 1'b0;

  // Reference model: arbiter occupancy derived from grant/start/end timestamps.
  typedef struct packed {
    logic [GW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;
  exp_t   exp_q[$];
  bit     occ  = 1'b0;
  int     last = N - 1;
  int     g_c, st_c, en_c;
  int     grants[$];
  int     grant_cyc[$];
  int     txv_cyc[$];
  int     fall_cyc[$];
  int     n_err_seen = 0;
  logic [W-1:0] held;

  // Transmitter model state.
  bit drop_next = 1'b0;
  bit rnd_busy  = 1'b0;
  bit pend_b    = 1'b0;
  int bz_extra  = 0;
  int bz_len    = 4;
  int rise_wait = 0;
  int busy_left = 0;
  int ext_left  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int rr(int lst, logic [N-1:0] v);
    logic [N-1:0] s;
    for (int i = 1; i <= N; i++) begin
      s = v >> ((lst + i) % N);
      if (s[0]) return (lst + i) % N;
    end
    return -1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         m_b, m_err, m_txv;
  logic [N-1:0] m_v, m_rdy;
  int           m_w;
  exp_t         m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs",
              {o_req_ready, o_tx_valid, o_tx_data, o_grant_id, o_active, o_err}, 64'd0);
        occ = 1'b0; last = N - 1; acc = '0;
        exp_q.delete(); grants.delete(); grant_cyc.delete();
        txv_cyc.delete(); fall_cyc.delete();
      end else begin
        m_b = i_tx_busy; m_v = i_req_valid; m_err = 1'b0;
        if (occ && st_c < 0 && cyc == g_c + 2 + TO) begin
          m_err = 1'b1; occ = 1'b0;
        end
        if (occ && en_c >= 0 && cyc == en_c + 1) occ = 1'b0;
        m_txv = occ && (cyc == g_c + 1);
        m_rdy = '0; m_w = -1;
        if (!occ && !m_b && m_v != '0) begin
          m_w = rr(last, m_v);
          m_rdy = N'(1) << m_w;
        end
        check("req_ready", o_req_ready, m_rdy);
        check("tx_valid", o_tx_valid, m_txv);
        check("active", o_active, occ);
        check("err", o_err, m_err);
        if (o_err) n_err_seen++;
        if (o_tx_valid) begin
          txv_flag = 1'b1;
          txv_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL tx_frame: got o_tx_valid expected no frame (cycle %0d)", cyc);
          end else begin
            m_e = exp_q.pop_front();
            check("tx_data", o_tx_data, m_e.data);
            check("grant_id", o_grant_id, m_e.id);
          end
          held = o_tx_data;
        end else if (occ && cyc > g_c + 1) begin
          check("tx_data_hold", o_tx_data, held);
        end
        if (occ && st_c < 0 && cyc >= g_c + 2 && m_b) begin
          st_c = cyc;
        end else if (occ && st_c >= 0 && en_c < 0 && cyc > st_c && !m_b) begin
          en_c = cyc;
          fall_cyc.push_back(cyc);
        end
        if (m_w >= 0) begin
          occ = 1'b1; g_c = cyc; st_c = -1; en_c = -1; last = m_w;
          m_e.id   = GW'(m_w);
          m_e.data = W'(i_req_data >> (m_w * W));
          exp_q.push_back(m_e);
          grants.push_back(m_w);
          grant_cyc.push_back(cyc);
        end
        acc = o_req_ready;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_reqs();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    v = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        v = v | (N'(1) << k);
        d = d | ((N*W)'(rq[k][0]) << (k * W));
      end
    end
    i_req_valid = v;
    i_req_data  = d;
  endtask

  task automatic step();
    bit dr;
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    end
    acc = '0;
    if (txv_flag) begin
      txv_flag = 1'b0;
      if (rnd_busy) begin
        bz_extra = $urandom_range(0, 3);
        bz_len   = $urandom_range(1, 8);
      end
      dr = drop_next || (rnd_busy && $urandom_range(0, 7) == 0);
      drop_next = 1'b0;
      if (!dr) begin
        pend_b = 1'b1; rise_wait = bz_extra;
      end
    end
    if (pend_b) begin
      if (rise_wait == 0) begin
        pend_b = 1'b0; busy_left = bz_len;
      end else begin
        rise_wait--;
      end
    end
    i_tx_busy = (busy_left > 0) || (ext_left > 0);
    if (busy_left > 0) busy_left--;
    if (ext_left > 0) ext_left--;
    drive_reqs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    busy_left = 0; ext_left = 0; pend_b = 1'b0; drop_next = 1'b0; txv_flag = 1'b0;
    i_tx_busy = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(string nm, int limit);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < limit) begin
      pending = occ || pend_b || busy_left > 0 || ext_left > 0;
      for (int k = 0; k < N; k++) if (rq[k].size() > 0) pending = 1'b1;
      if (pending) begin
        step(); n++;
      end
    end
    check({"drain_", nm}, pending, 1'b0);
  endtask

  task automatic check_grants(string nm, input int e[$]);
    check({nm, "_count"}, grants.size() >= e.size(), 1'b1);
    for (int i = 0; i < e.size() && i < grants.size(); i++) begin
      check(nm, grants[i], e[i]);
    end
  endtask

  initial begin
    int e[$];
    int c0, n, n0;
    rst_n = 1'b1; i_req_valid = '0; i_req_data = '0; i_tx_busy = 1'b0;
    #1;

    // Two alternating requesters, busy 1 cycle after valid for 12 cycles.
    do_reset();
    bz_extra = 0; bz_len = 12;
    rq[0].push_back(8'hA0); rq[0].push_back(8'hA1);
    rq[2].push_back(8'hC0); rq[2].push_back(8'hC1);
    drain("pair", 400);
    e = '{0, 2, 0, 2};
    check_grants("grant_pair", e);

    // All four requesters continuously valid.
    do_reset();
    bz_len = 3;
    for (int k = 0; k < N; k++) begin
      rq[k].push_back(W'(8'h10 + k)); rq[k].push_back(W'(8'h20 + k));
    end
    drain("all4", 400);
    e = '{0, 1, 2, 3, 0};
    check_grants("grant_all4", e);
    check("frames_per_grant", txv_cyc.size(), grants.size());

    // Start timeout: first frame never picked up, requester 1 not re-favoured.
    do_reset();
    drop_next = 1'b1; bz_len = 4;
    rq[1].push_back(8'h51); rq[1].push_back(8'h52); rq[2].push_back(8'h62);
    n0 = n_err_seen;
    drain("timeout", 300);
    check("timeout_err_count", n_err_seen - n0, 1);
    e = '{1, 2, 1};
    check_grants("grant_timeout", e);

    // External busy in IDLE holds off every grant until it falls.
    do_reset();
    ext_left = 8;
    rq[0].push_back(8'h3C); rq[3].push_back(8'hC3);
    step();
    c0 = cyc;
    drain("extbusy", 300);
    check("extbusy_grants", grant_cyc.size(), 2);
    if (grant_cyc.size() > 0) check("extbusy_first_grant_cycle", grant_cyc[0], c0 + 8);

    // Reset during WAIT_END with requester 3 granted.
    do_reset();
    bz_extra = 0; bz_len = 10;
    for (int k = 0; k < N; k++) rq[k].push_back(W'(8'h70 + k));
    n = 0;
    while (txv_cyc.size() < 4 && n < 400) begin
      step(); n++;
    end
    check("rst_setup_reached", txv_cyc.size() >= 4, 1'b1);
    repeat (3) step();
    e = '{0, 1, 2, 3};
    check_grants("grant_pre_rst", e);
    do_reset();
    rq[0].push_back(8'h80); rq[2].push_back(8'h82);
    drain("post_rst", 300);
    e = '{0, 2};
    check_grants("grant_post_rst", e);

    // Single persistent requester: back-to-back frames.
    do_reset();
    bz_extra = 0; bz_len = 5;
    for (int i = 0; i < 4; i++) rq[1].push_back(W'(8'h90 + i));
    drain("single", 300);
    check("single_txv_count", txv_cyc.size(), 4);
    check("single_fall_count", fall_cyc.size(), 4);
    for (int k = 0; k + 1 < txv_cyc.size() && k < fall_cyc.size(); k++) begin
      check("b2b_gap", txv_cyc[k+1] - fall_cyc[k], 2);
    end

    // Randomized traffic, busy timing, drops and external busy.
    do_reset();
    rnd_busy = 1'b1;
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0 && rq[k].size() < 3) rq[k].push_back(W'($urandom));
      end
      if ($urandom_range(0, 39) == 0 && ext_left == 0) ext_left = $urandom_range(1, 5);
      step();
    end
    drain("random", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, width of one frame payload.
REQ-003 SHALL have parameter TIMEOUT, default 16, cycles allowed from o_tx_valid until i_tx_busy rises (1..255).
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  NUM_REQ  per-requester frame-pending flag.
REQ-007 SHALL have port i_req_data  input  NUM_REQ*DATA_W  payloads; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port o_req_ready  output  NUM_REQ  per-requester accept strobe, one-hot or zero.
REQ-009 SHALL have port o_tx_data  output  DATA_W  payload to transmitter, registered.
REQ-010 SHALL have port o_tx_valid  output  1  one-cycle frame-start strobe to transmitter.
REQ-011 SHALL have port i_tx_busy  input  1  transmitter busy flag.
REQ-012 SHALL have port o_grant_id  output  clog2(NUM_REQ)  index of the current or most recent grant.
REQ-013 SHALL have port o_active  output  1  high when state is not IDLE.
REQ-014 SHALL have port o_err  output  1  one-cycle pulse on start timeout.

Function
REQ-015 SHALL implement states IDLE, LOAD, WAIT_START, WAIT_END.
REQ-016 IDLE: if any i_req_valid=1 and i_tx_busy=0, SHALL select a winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 IDLE with a winner: SHALL drive o_req_ready[winner]=1 combinationally in that cycle, capture the winner's payload into o_tx_data, set last_grant and o_grant_id to the winner, and go to LOAD.
REQ-018 IDLE with i_tx_busy=1: SHALL grant nothing and stay in IDLE.
REQ-019 o_req_ready SHALL be 0 in all states other than IDLE; at most one bit SHALL be high in any cycle.
REQ-020 LOAD: SHALL drive o_tx_valid=1 for exactly one cycle and go to WAIT_START; o_tx_data SHALL hold stable from LOAD until the next grant.
REQ-021 WAIT_START: SHALL clear an 8-bit timeout counter on entry and increment it each cycle while i_tx_busy=0.
REQ-022 WAIT_START: when i_tx_busy=1, SHALL go to WAIT_END.
REQ-023 WAIT_START: when the counter reaches TIMEOUT with i_tx_busy still 0, SHALL pulse o_err for one cycle, drop the frame, and go to IDLE; last_grant SHALL keep the dropped requester.
REQ-024 WAIT_END: when i_tx_busy=0, SHALL go to IDLE; the next grant is possible in the following cycle.
REQ-025 Requesters SHALL hold valid and data until ready; a requester dropping valid before ready SHALL have no effect on the arbiter.
REQ-026 Requests arriving while state is not IDLE SHALL wait; no request is lost or reordered within a requester.
REQ-027 With a single persistent requester, the arbiter SHALL grant it back-to-back, with no starvation-induced gaps.
REQ-028 o_active SHALL be a registered or state-decoded output equal to (state != IDLE).

Reset
REQ-029 Asserting i_rst_n=0 in any state SHALL immediately force IDLE, with o_req_ready=0, o_tx_valid=0, o_tx_data=0, o_grant_id=0, o_active=0, o_err=0, and counter=0.
REQ-030 Reset SHALL set last_grant=NUM_REQ-1, so that requester 0 wins first.
REQ-031 A frame in progress at reset SHALL be abandoned without any ready or error indication.

Verification
REQ-032 After reset, i_req_valid=4'b0101, busy model rising 1 cycle after valid and falling 12 cycles later -> grants 0, 2, 0, 2 in order; o_tx_data matches each payload.
REQ-033 All four requesters valid continuously -> grant sequence 0, 1, 2, 3, 0; exactly one o_req_ready pulse per frame.
REQ-034 i_tx_busy held 0 after o_tx_valid, TIMEOUT=16 -> o_err pulses once 16 cycles after WAIT_START entry, state returns to IDLE, and the same requester is not re-favoured.
REQ-035 i_tx_busy=1 externally while in IDLE with requests pending -> no o_req_ready until busy falls.
REQ-036 Assert i_rst_n=0 during WAIT_END with req 3 granted -> all outputs 0 that cycle; after release, req 0 wins if valid.
REQ-037 Single requester 1 always valid -> consecutive frames, with o_tx_valid asserted 2 cycles after each busy fall.
